// File: rtl/i2c_sync_fifo.sv
// ---------------------------------------------------------------------------
// i2c_sync_fifo
// Single-clock FIFO that sits between the APB register block and the I2C core.
// Two instances are used: one for transmit bytes, one for receive bytes.
//
// The register block holds a FIFO enable high for several pclk cycles on each
// APB access. For that reason each port can turn a held enable into exactly
// one operation by detecting its rising edge (WR_EDGE / RD_EDGE = 1).
//
// Ports:
//   pclk_i      : clock, all state changes on the rising edge
//   preset_n_i  : asynchronous reset, active-low
//   clear_i     : synchronous flush, active-high, overrides push/pop
//   wr_en_i     : write request (level or edge, selected by WR_EDGE)
//   wr_data_i   : write data, sampled on the edge that accepts the push
//   rd_en_i     : read request (level or edge, selected by RD_EDGE)
//   rd_data_o   : registered read data, held until the next accepted pop
//   full_o      : FIFO holds DEPTH words
//   empty_o     : FIFO holds no words
//   count_o     : occupancy, 0..DEPTH
//   overflow_o  : sticky, set when a push was rejected
//   underflow_o : sticky, set when a pop was rejected
// ---------------------------------------------------------------------------
module i2c_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter bit WR_EDGE    = 1'b1,
  parameter bit RD_EDGE    = 1'b1
) (
  input  logic                  pclk_i,
  input  logic                  preset_n_i,
  input  logic                  clear_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  // XOR of the two pointers equals this exactly when the FIFO is full.
  localparam logic [PW-1:0] FULL_XOR = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  wr_req, rd_req;
  logic                  push_ok, pop_ok;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;

  assign wr_idx = wr_ptr_q[ADDR_WIDTH-1:0];
  assign rd_idx = rd_ptr_q[ADDR_WIDTH-1:0];

  always_comb begin
    // The enable history keeps sampling during clear, so an enable that is
    // held across a clear does not look like a fresh request afterwards.
    wr_en_d = wr_en_i;
    rd_en_d = rd_en_i;

    wr_req = WR_EDGE ? (wr_en_i & ~wr_en_q) : wr_en_i;
    rd_req = RD_EDGE ? (rd_en_i & ~rd_en_q) : rd_en_i;

    // When full, a push is still accepted if a pop frees a slot in the same
    // cycle. When empty, the pop is rejected, so there is no write-through.
    pop_ok  = rd_req & ~empty_q;
    push_ok = wr_req & (~full_q | pop_ok);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_data_d   = rd_data_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we      = 1'b0;

    if (clear_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      rd_data_d   = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (pop_ok) begin
        // On a full push+pop the slot is both read and written this edge.
        // The read sees the old word because the memory write is non-blocking.
        rd_data_d = mem[rd_idx];
        rd_ptr_d  = rd_ptr_q + PTR_ONE;
      end
      if (push_ok) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (wr_req && !push_ok) begin
        overflow_d = 1'b1;
      end
      if (rd_req && !pop_ok) begin
        underflow_d = 1'b1;
      end
    end

    // Flags are derived from the next pointers, so the registered flags and
    // count_o always agree with each other in the same cycle.
    count_d = wr_ptr_d - rd_ptr_d;
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = ((wr_ptr_d ^ rd_ptr_d) == FULL_XOR);
  end

  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // The storage array has no reset. Words are only read after they are written.
  always_ff @(posedge pclk_i) begin
    if (mem_we) begin
      mem[wr_idx] <= wr_data_i;
    end
  end

  assign rd_data_o   = rd_data_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_i2c_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_i2c_sync_fifo
// Self-checking bench for i2c_sync_fifo with DEPTH=4.
//
// The main instance uses edge-triggered push and pop. It is driven from a
// table of one-cycle vectors. Each vector carries its expected count and flags.
// Read data is predicted by a queue model of the FIFO. Every accepted pop
// pushes its expected word onto a scoreboard, and that word is popped again
// when the DUT output is sampled.
//
// A second instance uses a level-sensitive write. It covers the held-enable
// case, where every high cycle is a push.
// ---------------------------------------------------------------------------
module tb_i2c_sync_fifo;

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       rd;
    logic       clr;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
  } vec_t;

  logic       pclk = 1'b0;
  logic       preset_n;
  logic       clear;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       full, empty, overflow, underflow;
  logic [2:0] count;

  logic       lvl_wr_en;
  logic [7:0] lvl_wr_data;
  logic       lvl_rd_en;
  logic [7:0] lvl_rd_data;
  logic       lvl_full, lvl_empty, lvl_overflow, lvl_underflow;
  logic [2:0] lvl_count;

  int compared = 0;
  int mismatched = 0;

  vec_t       vecs[$];
  logic [7:0] model_q[$];
  logic [7:0] sb_q[$];
  logic [7:0] exp_rd_data;
  logic       prev_wr, prev_rd;

  always #5 pclk = ~pclk;

  i2c_sync_fifo #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .WR_EDGE(1'b1), .RD_EDGE(1'b1)
  ) dut (
    .pclk_i(pclk), .preset_n_i(preset_n), .clear_i(clear),
    .wr_en_i(wr_en), .wr_data_i(wr_data), .rd_en_i(rd_en),
    .rd_data_o(rd_data), .full_o(full), .empty_o(empty), .count_o(count),
    .overflow_o(overflow), .underflow_o(underflow)
  );

  i2c_sync_fifo #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .WR_EDGE(1'b0), .RD_EDGE(1'b1)
  ) dut_lvl (
    .pclk_i(pclk), .preset_n_i(preset_n), .clear_i(1'b0),
    .wr_en_i(lvl_wr_en), .wr_data_i(lvl_wr_data), .rd_en_i(lvl_rd_en),
    .rd_data_o(lvl_rd_data), .full_o(lvl_full), .empty_o(lvl_empty),
    .count_o(lvl_count), .overflow_o(lvl_overflow), .underflow_o(lvl_underflow)
  );

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic void addVec(input logic wr, input logic [7:0] data, input logic rd,
                                 input logic clr, input logic [2:0] cnt, input logic fl,
                                 input logic em, input logic ovf, input logic unf);
    vec_t v;
    v.wr = wr; v.data = data; v.rd = rd; v.clr = clr;
    v.cnt = cnt; v.full = fl; v.empty = em; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string tag, input logic [2:0] cnt, input logic fl,
                             input logic em, input logic ovf, input logic unf);
    compare({tag, " rd_data"}, 32'(rd_data), 32'(exp_rd_data));
    compare({tag, " count"}, 32'(count), 32'(cnt));
    compare({tag, " full"}, 32'(full), 32'(fl));
    compare({tag, " empty"}, 32'(empty), 32'(em));
    compare({tag, " overflow"}, 32'(overflow), 32'(ovf));
    compare({tag, " underflow"}, 32'(underflow), 32'(unf));
  endtask

  // Drives one vector just after a falling edge. Updates the reference model
  // with the requests the rising edge will see, then samples on the next
  // falling edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    logic wr_req, rd_req, pop_ok, push_ok;
    wr_en   = v.wr;
    wr_data = v.data;
    rd_en   = v.rd;
    clear   = v.clr;
    wr_req  = v.wr & ~prev_wr;
    rd_req  = v.rd & ~prev_rd;
    prev_wr = v.wr;
    prev_rd = v.rd;
    if (v.clr) begin
      model_q.delete();
      sb_q.delete();
    end else begin
      pop_ok  = rd_req && (model_q.size() > 0);
      push_ok = wr_req && ((model_q.size() < 4) || pop_ok);
      if (pop_ok) sb_q.push_back(model_q.pop_front());
      if (push_ok) model_q.push_back(v.data);
    end
    @(negedge pclk);
    if (v.clr) exp_rd_data = 8'h00;
    else if (sb_q.size() > 0) exp_rd_data = sb_q.pop_front();
    checkOutput($sformatf("v%0d", idx), v.cnt, v.full, v.empty, v.ovf, v.unf);
  endtask

  initial begin
    preset_n = 1'b0; clear = 1'b0; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;
    lvl_wr_en = 1'b0; lvl_wr_data = 8'h00; lvl_rd_en = 1'b0;
    prev_wr = 1'b0; prev_rd = 1'b0; exp_rd_data = 8'h00;

    // Edge-detected write held high for three cycles: a single push.
    addVec(1, 8'hA5, 0, 0, 1, 0, 0, 0, 0);
    addVec(1, 8'hA5, 0, 0, 1, 0, 0, 0, 0);
    addVec(1, 8'hA5, 0, 0, 1, 0, 0, 0, 0);
    addVec(0, 8'h00, 0, 0, 1, 0, 0, 0, 0);
    addVec(0, 8'h00, 1, 0, 0, 0, 1, 0, 0);
    addVec(0, 8'h00, 0, 0, 0, 0, 1, 0, 0);
    // Fill, then overflow, then drain in order.
    addVec(1, 8'h11, 0, 0, 1, 0, 0, 0, 0);
    addVec(0, 8'h00, 0, 0, 1, 0, 0, 0, 0);
    addVec(1, 8'h22, 0, 0, 2, 0, 0, 0, 0);
    addVec(0, 8'h00, 0, 0, 2, 0, 0, 0, 0);
    addVec(1, 8'h33, 0, 0, 3, 0, 0, 0, 0);
    addVec(0, 8'h00, 0, 0, 3, 0, 0, 0, 0);
    addVec(1, 8'h44, 0, 0, 4, 1, 0, 0, 0);
    addVec(0, 8'h00, 0, 0, 4, 1, 0, 0, 0);
    addVec(1, 8'h55, 0, 0, 4, 1, 0, 1, 0);
    addVec(0, 8'h00, 0, 0, 4, 1, 0, 1, 0);
    addVec(0, 8'h00, 1, 0, 3, 0, 0, 1, 0);
    addVec(0, 8'h00, 0, 0, 3, 0, 0, 1, 0);
    addVec(0, 8'h00, 1, 0, 2, 0, 0, 1, 0);
    addVec(0, 8'h00, 0, 0, 2, 0, 0, 1, 0);
    addVec(0, 8'h00, 1, 0, 1, 0, 0, 1, 0);
    addVec(0, 8'h00, 0, 0, 1, 0, 0, 1, 0);
    addVec(0, 8'h00, 1, 0, 0, 0, 1, 1, 0);
    addVec(0, 8'h00, 0, 0, 0, 0, 1, 1, 0);
    // Underflow, then push and pop together on an empty FIFO.
    addVec(0, 8'h00, 1, 0, 0, 0, 1, 1, 1);
    addVec(0, 8'h00, 0, 0, 0, 0, 1, 1, 1);
    addVec(1, 8'h66, 1, 0, 1, 0, 0, 1, 1);
    addVec(0, 8'h00, 0, 0, 1, 0, 0, 1, 1);
    addVec(0, 8'h00, 1, 0, 0, 0, 1, 1, 1);
    addVec(0, 8'h00, 0, 0, 0, 0, 1, 1, 1);
    // Full FIFO with push and pop together, then drain across the pointer wrap.
    addVec(1, 8'h11, 0, 0, 1, 0, 0, 1, 1);
    addVec(0, 8'h00, 0, 0, 1, 0, 0, 1, 1);
    addVec(1, 8'h22, 0, 0, 2, 0, 0, 1, 1);
    addVec(0, 8'h00, 0, 0, 2, 0, 0, 1, 1);
    addVec(1, 8'h33, 0, 0, 3, 0, 0, 1, 1);
    addVec(0, 8'h00, 0, 0, 3, 0, 0, 1, 1);
    addVec(1, 8'h44, 0, 0, 4, 1, 0, 1, 1);
    addVec(0, 8'h00, 0, 0, 4, 1, 0, 1, 1);
    addVec(1, 8'h77, 1, 0, 4, 1, 0, 1, 1);
    addVec(0, 8'h00, 0, 0, 4, 1, 0, 1, 1);
    addVec(0, 8'h00, 1, 0, 3, 0, 0, 1, 1);
    addVec(0, 8'h00, 0, 0, 3, 0, 0, 1, 1);
    addVec(0, 8'h00, 1, 0, 2, 0, 0, 1, 1);
    addVec(0, 8'h00, 0, 0, 2, 0, 0, 1, 1);
    addVec(0, 8'h00, 1, 0, 1, 0, 0, 1, 1);
    addVec(0, 8'h00, 0, 0, 1, 0, 0, 1, 1);
    addVec(0, 8'h00, 1, 0, 0, 0, 1, 1, 1);
    addVec(0, 8'h00, 0, 0, 0, 0, 1, 1, 1);
    // Clear beats a push in the same cycle. A write held through the clear
    // must not push afterwards.
    addVec(1, 8'hAA, 0, 0, 1, 0, 0, 1, 1);
    addVec(0, 8'h00, 0, 0, 1, 0, 0, 1, 1);
    addVec(1, 8'hBB, 0, 0, 2, 0, 0, 1, 1);
    addVec(0, 8'h00, 0, 0, 2, 0, 0, 1, 1);
    addVec(1, 8'hCC, 0, 1, 0, 0, 1, 0, 0);
    addVec(1, 8'hCC, 0, 0, 0, 0, 1, 0, 0);
    addVec(0, 8'h00, 0, 0, 0, 0, 1, 0, 0);
    // Load three words ahead of the asynchronous reset check.
    addVec(1, 8'h01, 0, 0, 1, 0, 0, 0, 0);
    addVec(0, 8'h00, 0, 0, 1, 0, 0, 0, 0);
    addVec(1, 8'h02, 0, 0, 2, 0, 0, 0, 0);
    addVec(0, 8'h00, 0, 0, 2, 0, 0, 0, 0);
    addVec(1, 8'h03, 0, 0, 3, 0, 0, 0, 0);
    addVec(0, 8'h00, 0, 0, 3, 0, 0, 0, 0);

    // Reset state
    @(negedge pclk);
    @(negedge pclk);
    checkOutput("reset", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    preset_n = 1'b1;
    @(negedge pclk);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
    end

    // Asynchronous reset between clock edges. The falling edge was 3 ns ago
    // and the next rising edge is 2 ns away.
    compare("pre-reset count", 32'(count), 32'd3);
    #2 preset_n = 1'b0;
    #1;
    exp_rd_data = 8'h00;
    checkOutput("async reset", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    model_q.delete(); sb_q.delete();
    prev_wr = 1'b0; prev_rd = 1'b0;
    @(negedge pclk);
    preset_n = 1'b1;
    @(negedge pclk);

    // Level-sensitive write: each high cycle pushes one word.
    for (int i = 0; i < 4; i++) begin
      lvl_wr_en   = 1'b1;
      lvl_wr_data = 8'(i + 1);
      @(negedge pclk);
      compare($sformatf("lvl count %0d", i), 32'(lvl_count), 32'(i + 1));
      compare($sformatf("lvl full %0d", i), 32'(lvl_full), (i == 3) ? 32'd1 : 32'd0);
    end
    lvl_wr_data = 8'h09;
    @(negedge pclk);
    compare("lvl overflow", 32'(lvl_overflow), 32'd1);
    compare("lvl count held", 32'(lvl_count), 32'd4);
    lvl_wr_en = 1'b0;
    lvl_rd_en = 1'b1;
    @(negedge pclk);
    lvl_rd_en = 1'b0;
    compare("lvl first word", 32'(lvl_rd_data), 32'h01);
    compare("lvl count after pop", 32'(lvl_count), 32'd3);
    compare("lvl empty", 32'(lvl_empty), 32'd0);
    compare("lvl underflow", 32'(lvl_underflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
